// File: rtl/ysyx_23060221_ifu.sv
// rtl/ysyx_23060221_ifu.sv - instruction fetch unit: AXI-lite-style read master feeding decode
// Optional IFU_PERF_EN adds fetch-count and fetch-cycle performance counters.
module ysyx_23060221_ifu #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] araddr,
   output logic        arvalid,
   input  logic        arready,
   input  logic [31:0] rdata,
   input  logic [1:0]  rresp,
   input  logic        rvalid,
   output logic        rready,
   output logic [31:0] inst,
   output logic [31:0] pc,
   output logic        IFU_valid,
   input  logic        IDU_ready,
   input  logic        npc_valid,
   input  logic [31:0] npc,
   output logic        fetch_err,
   output logic [31:0] perf_fetch_cnt,
   output logic [31:0] perf_fetch_cyc
);

   typedef enum logic [2:0] {IDLE, REQ, RESP, OUT, WPC} state_t;

   state_t state, state_next;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Handshake outputs depend on state alone, so they are mutually exclusive by construction.
   always_comb begin
      state_next = state;
      arvalid    = 1'b0;
      rready     = 1'b0;
      IFU_valid  = 1'b0;
      case (state)
         IDLE: state_next = REQ;
         REQ: begin
            arvalid = 1'b1;
            if (arready) state_next = RESP;
         end
         RESP: begin
            rready = 1'b1;
            if (rvalid) state_next = OUT;
         end
         OUT: begin
            IFU_valid = 1'b1;
            if (IDU_ready) state_next = WPC;
         end
         WPC: begin
            if (npc_valid) state_next = REQ;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc        <= RESET_PC;
         inst      <= 32'd0;
         fetch_err <= 1'b0;
      end else begin
         if (state == RESP && rvalid) begin
            inst <= rdata;
            if (rresp != 2'b00) fetch_err <= 1'b1;
         end
         // A misaligned next PC is flagged but still fetched as given.
         if (state == WPC && npc_valid) begin
            pc <= npc;
            if (npc[1:0] != 2'b00) fetch_err <= 1'b1;
         end
      end
   end

   assign araddr = pc;

`ifdef IFU_PERF_EN
   logic [31:0] fetch_cnt_q;
   logic [31:0] fetch_cyc_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_cnt_q <= 32'd0;
         fetch_cyc_q <= 32'd0;
      end else begin
         if (rvalid && rready) fetch_cnt_q <= fetch_cnt_q + 32'd1;
         if (state == REQ || state == RESP) fetch_cyc_q <= fetch_cyc_q + 32'd1;
      end
   end

   assign perf_fetch_cnt = fetch_cnt_q;
   assign perf_fetch_cyc = fetch_cyc_q;
`else
   assign perf_fetch_cnt = 32'd0;
   assign perf_fetch_cyc = 32'd0;
`endif

endmodule

// File: doc/ysyx_23060221_ifu.md
YSYX_23060221_IFU -- requirements
Module: ysyx_23060221_ifu

Interface
REQ-001 SHALL have parameter: RESET_PC, 32'h8000_0000, PC loaded on reset.
REQ-002 SHALL have ports: clk  in  1  clock; rst  in  1  reset (synchronous, active-high).
REQ-003 SHALL have port: araddr  out  32  instruction read address.
REQ-004 SHALL have ports: arvalid  out  1 / arready  in  1  read-address handshake.
REQ-005 SHALL have ports: rdata  in  32 / rresp  in  2 / rvalid  in  1 / rready  out  1  read-data handshake.
REQ-006 SHALL have ports: inst  out  32 / pc  out  32  fetched instruction and its address, to decode.
REQ-007 SHALL have ports: IFU_valid  out  1 / IDU_ready  in  1  fetch-to-decode handshake.
REQ-008 SHALL have ports: npc_valid  in  1 / npc  in  32  next PC from the back end.
REQ-009 SHALL have port: fetch_err  out  1  sticky fetch-error flag.
REQ-010 SHALL have ports: perf_fetch_cnt  out  32 / perf_fetch_cyc  out  32  performance counters.

Function
REQ-011 SHALL implement FSM states IDLE, REQ, RESP, OUT, WPC; all outputs registered or decoded from state only.
REQ-012 IDLE SHALL move to REQ unconditionally on the next clk.
REQ-013 In REQ: arvalid=1, araddr=pc; on arvalid&arready SHALL move to RESP; arvalid SHALL NOT drop before arready.
REQ-014 In RESP: rready=1; on rvalid SHALL latch rdata into inst and move to OUT.
REQ-015 In RESP, rvalid with rresp!=2'b00 SHALL set fetch_err; inst still latched; flow continues.
REQ-016 In OUT: IFU_valid=1; inst and pc SHALL be stable; on IFU_valid&IDU_ready SHALL move to WPC.
REQ-017 In WPC: on npc_valid SHALL load pc<=npc and move to REQ.
REQ-018 npc_valid in any state other than WPC SHALL be ignored; pc unchanged.
REQ-019 npc[1:0]!=2'b00 accepted in WPC SHALL set fetch_err; the fetch SHALL still issue with araddr=npc unmodified.
REQ-020 arready and rvalid asserted in the same REQ cycle: rvalid SHALL be ignored, since rready=0 in REQ.
REQ-021 With zero-wait memory (arready high in REQ, rvalid high on the first RESP cycle), IFU_valid SHALL rise 2 cycles after the REQ cycle.
REQ-022 arvalid, rready and IFU_valid SHALL be mutually exclusive, at most one high per cycle.
REQ-023 fetch_err SHALL be sticky until reset.

Reset
REQ-024 On rst: state=IDLE, pc=RESET_PC, inst=0, fetch_err=0, counters=0; arvalid=rready=IFU_valid=0.
REQ-025 rst asserted in any state SHALL abandon the outstanding transaction; any response arriving later with rready=0 SHALL be ignored.
REQ-026 The first REQ after rst deasserts SHALL use araddr=RESET_PC.

Configuration
REQ-027 Macro IFU_PERF_EN defined: perf_fetch_cnt SHALL increment on each rvalid&rready.
REQ-028 Macro IFU_PERF_EN defined: perf_fetch_cyc SHALL increment every cycle in REQ or RESP.
REQ-029 Both IFU_PERF_EN counters SHALL wrap modulo 2^32.
REQ-030 Macro IFU_PERF_EN undefined: both counter outputs SHALL be constant 0 and no counter flops SHALL be synthesised.

Verification
REQ-031 Reset then zero-wait memory returning 32'h00000013 -> araddr=32'h80000000 on the first REQ cycle; IFU_valid 2 cycles later with inst=32'h00000013, pc=32'h80000000.
REQ-032 arready delayed 3 cycles, rvalid delayed 2 cycles -> arvalid held 4 cycles with araddr constant; rready high 3 cycles; single inst capture.
REQ-033 IDU_ready low 5 cycles in OUT -> IFU_valid, inst and pc constant for all 5 cycles; WPC entered only after IDU_ready=1.
REQ-034 npc_valid pulse with npc=32'h80000100 during RESP (ignored), then npc=32'h80000004 in WPC -> next araddr=32'h80000004.
REQ-035 rresp=2'b10 on a fetch -> fetch_err=1 and remains 1 after 3 more clean fetches; npc=32'h80000002 in WPC also sets fetch_err.
REQ-036 rst asserted in RESP, with rvalid arriving the cycle after -> state IDLE, rready=0, inst=0; next araddr=32'h80000000. With IFU_PERF_EN defined, 10 zero-wait fetches -> perf_fetch_cnt=10, perf_fetch_cyc=20.
